// File: rtl/act_lut_interp_sched.sv
// Round-robin scheduler that shares one activation LUT among N_REQ requesters
// and linearly interpolates between the base/next entries it returns.
module act_lut_interp_sched #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned FRAC_W = DATA_W - ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]         lut_address,
    input  logic [DATA_W-1:0]         lut_base,
    input  logic [DATA_W-1:0]         lut_next,
    output logic                      resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic [N_REQ-1:0]          resp_id,
    input  logic                      resp_ready,
    output logic                      busy
);

    localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned PROD_W = DATA_W + FRAC_W + 2;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - PROD_W'(1);

    typedef enum logic [1:0] {IDLE, LOOKUP, CALC, RESP} state_e;

    state_e                     state_q, state_d;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]           g_q, g_d;
    logic [FRAC_W-1:0]          frac_q, frac_d;
    logic [N_REQ-1:0]           id_q, id_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic signed [DATA_W-1:0]   base_q, base_d;
    logic signed [DATA_W-1:0]   next_q, next_d;
    logic                       rv_q, rv_d;
    logic [DATA_W-1:0]          rd_q, rd_d;
    logic [N_REQ-1:0]           rid_q, rid_d;

    logic                       grant_found;
    logic [PTR_W-1:0]           grant_idx;
    int unsigned                scan_idx;

    logic signed [DIFF_W-1:0]   diff;
    logic signed [FRAC_W:0]     frac_s;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   interp;
    logic [DATA_W-1:0]          sat_y;
    logic [DATA_W-1:0]          grant_data;

    // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
            if (!grant_found && req_valid[PTR_W'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // Interpolation: base + floor((next-base)*frac / 2^FRAC_W), saturated.
    always_comb begin
        diff   = DIFF_W'(next_q) - DIFF_W'(base_q);
        frac_s = $signed({1'b0, frac_q});
        prod   = PROD_W'(diff) * PROD_W'(frac_s);
        interp = PROD_W'(base_q) + (prod >>> FRAC_W);
        if (interp > SAT_MAX)      sat_y = DATA_W'(SAT_MAX);
        else if (interp < SAT_MIN) sat_y = DATA_W'(SAT_MIN);
        else                       sat_y = interp[DATA_W-1:0];
    end

    assign grant_data = req_data[32'(grant_idx)*DATA_W +: DATA_W];

    // Next-state and accept-strobe logic.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        g_d       = g_q;
        frac_d    = frac_q;
        id_d      = id_q;
        addr_d    = addr_q;
        base_d    = base_q;
        next_d    = next_q;
        rv_d      = rv_q;
        rd_d      = rd_q;
        rid_d     = rid_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_found && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    g_d     = grant_idx;
                    frac_d  = grant_data[FRAC_W-1:0];
                    id_d    = N_REQ'(1) << grant_idx;
                    addr_d  = grant_data[DATA_W-1 -: ADDR_W];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                base_d  = lut_base;
                next_d  = lut_next;
                state_d = CALC;
            end
            CALC: begin
                rd_d    = sat_y;
                rid_d   = id_q;
                rv_d    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    rv_d     = 1'b0;
                    rr_ptr_d = (g_q == PTR_W'(N_REQ - 1)) ? '0 : g_q + PTR_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            g_q      <= '0;
            frac_q   <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            base_q   <= '0;
            next_q   <= '0;
            rv_q     <= 1'b0;
            rd_q     <= '0;
            rid_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            g_q      <= g_d;
            frac_q   <= frac_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            next_q   <= next_d;
            rv_q     <= rv_d;
            rd_q     <= rd_d;
            rid_q    <= rid_d;
        end
    end

    assign lut_address = addr_q;
    assign resp_valid  = rv_q;
    assign resp_data   = rd_q;
    assign resp_id     = rid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_act_lut_interp_sched.sv
// Directed bench for act_lut_interp_sched with a linear 16-entry LUT model.
module tb_act_lut_interp_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  lut_address;
    logic [7:0]  lut_base;
    logic [7:0]  lut_next;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [3:0]  resp_id;
    logic        resp_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    act_lut_interp_sched #(.N_REQ(4), .DATA_W(8), .ADDR_W(4), .FRAC_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .lut_address(lut_address),
        .lut_base   (lut_base),
        .lut_next   (lut_next),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lut[i] = 16*i for i<8, 16*i-256 for i>=8 (two's complement of 16*i mod 256)
    function automatic logic [7:0] lut_val(input logic [3:0] a);
        return {a, 4'b0000};
    endfunction

    // LUT owns the clamp at 7 and the wrap at 15.
    always_comb begin
        lut_base = lut_val(lut_address);
        if (lut_address == 4'd7) lut_next = lut_val(4'd7);
        else                     lut_next = lut_val(lut_address + 4'd1);
    end

    // One full transaction with zero stall; checks grant, address, latency and result.
    task automatic run_one(input string name, input logic [3:0] vmask, input logic [31:0] data,
                           input int g, input logic [7:0] exp_y);
        logic [3:0] oh;
        logic [3:0] exp_addr;
        oh       = 4'b0001 << g;
        exp_addr = data[g*8+7 -: 4];
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = vmask;
        req_data   = data;
        #1;
        checks++;
        if (req_ready !== oh) begin
            errors++;
            $display("FAIL %s grant: req_ready=%b expected %b", name, req_ready, oh);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        req_data  = ~data;
        #1;
        checks++;
        if (lut_address !== exp_addr || busy !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s lookup: addr=%h busy=%b rv=%b expected addr=%h busy=1 rv=0",
                     name, lut_address, busy, resp_valid, exp_addr);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early_resp: resp_valid=%b expected 0", name, resp_valid);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== exp_y || resp_id !== oh) begin
            errors++;
            $display("FAIL %s result: rv=%b data=%0d id=%b expected rv=1 data=%0d id=%b",
                     name, resp_valid, $signed(resp_data), resp_id, $signed(exp_y), oh);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b rv=%b expected 0 0", name, busy, resp_valid);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_data   = 32'h25252525;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b0 || resp_valid !== 1'b0 ||
            resp_data !== 8'h00 || resp_id !== 4'b0000 || lut_address !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b busy=%b rv=%b data=%h id=%b addr=%h expected all 0",
                     req_ready, busy, resp_valid, resp_data, resp_id, lut_address);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_interp_basic();
        run_one("req0_x25", 4'b0001, 32'h00000025, 0, 8'd37);
    endtask

    task automatic test_edges();
        run_one("req1_clamp", 4'b0010, 32'h00007A00, 1, 8'd112);
        run_one("req2_wrap", 4'b0100, 32'h00F80000, 2, 8'hF8);
    endtask

    task automatic test_negative();
        run_one("req3_x83", 4'b1000, 32'h83000000, 3, 8'h83);
        run_one("req3_x80", 4'b1000, 32'h80000000, 3, 8'h80);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        int seq[5] = '{0, 1, 2, 3, 0};
        rst        = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        req_data   = 32'h25252525;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_rdy = (c % 4 == 0) ? (4'b0001 << seq[c/4]) : 4'b0000;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant cycle %0d: req_ready=%b expected %b", c, req_ready, exp_rdy);
            end
            if (c % 4 == 3) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== (4'b0001 << seq[c/4]) || resp_data !== 8'd37) begin
                    errors++;
                    $display("FAIL rr_resp cycle %0d: rv=%b id=%b data=%0d expected 1 %b 37",
                             c, resp_valid, resp_id, resp_data, 4'b0001 << seq[c/4]);
                end
            end
        end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: busy=%b expected 0", busy);
        end
        run_one("rr_req1", 4'b0010, 32'h00007A00, 1, 8'd112);
        run_one("rr_ptr2_1011", 4'b1011, 32'h83838383, 3, 8'h83);
    endtask

    task automatic test_stall();
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 4'b0001;
        req_data   = 32'h00007A25;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL stall_grant: req_ready=%b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0010;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 8'd37 || resp_id !== 4'b0001 ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold %0d: rv=%b data=%0d id=%b rdy=%b busy=%b expected 1 37 0001 0000 1",
                         i, resp_valid, resp_data, resp_id, req_ready, busy);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_release: busy=%b rv=%b rdy=%b expected 0 0 0010", busy, resp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 8'd112 || resp_id !== 4'b0010) begin
            errors++;
            $display("FAIL stall_next: rv=%b data=%0d id=%b expected 1 112 0010", resp_valid, resp_data, resp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        run_one("pre_abort_req0", 4'b0001, 32'h00000025, 0, 8'd37);
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = 32'h00F82580;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL abort_grant: req_ready=%b expected 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0011;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL abort_rst_ready: req_ready=%b expected 0000", req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 8'h00 || resp_id !== 4'b0000 ||
            lut_address !== 4'h0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL abort_state: rv=%b data=%h id=%b addr=%h busy=%b rdy=%b expected all 0",
                     resp_valid, resp_data, resp_id, lut_address, busy, req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL abort_regrant: req_ready=%b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 8'h80 || resp_id !== 4'b0001) begin
            errors++;
            $display("FAIL abort_result: rv=%b data=%h id=%b expected 1 80 0001", resp_valid, resp_data, resp_id);
        end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_data   = 32'h0;
        resp_ready = 1'b1;
        test_reset();
        test_interp_basic();
        test_edges();
        test_negative();
        test_round_robin();
        test_stall();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
